// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB completer memory and the AXI4-Lite-to-APB
// bridge that sits upstream of it.
//   APB_DW / APB_SW : APB data width and write-strobe width
//   apb_state_e     : completer transfer state
//   RESP_OKAY / RESP_SLVERR : AXI response codes the bridge derives from PSLVERR
// -----------------------------------------------------------------------------
package apb_pkg;

    localparam int unsigned APB_DW = 32;
    localparam int unsigned APB_SW = APB_DW / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } apb_state_e;

    // AXI response code for a completed APB transfer.
    function automatic logic [1:0] apb_resp(input logic slverr);
        return slverr ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage : apb_pkg

// File: rtl/apb_bytemem.sv
// -----------------------------------------------------------------------------
// apb_bytemem
// DEPTH x 32-bit word array with per-byte-lane write enables, an asynchronous
// read port and an asynchronous clear of every word on reset.
//   clk_i   : write clock, rising edge
//   rst_i   : asynchronous active-high clear of the whole array
//   we_i    : byte-lane write enables, bit i writes wdata_i[8i+7:8i]
//   addr_i  : word index shared by the read and write port
//   wdata_i : write data
//   rdata_o : combinational read data of word addr_i
// -----------------------------------------------------------------------------
module apb_bytemem
    import apb_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [APB_SW-1:0] we_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [APB_DW-1:0] wdata_i,
    output logic [APB_DW-1:0] rdata_o
);

    logic [APB_DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < APB_SW; b++) begin
                if (we_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule : apb_bytemem

// File: rtl/apb_slave_mem.sv
// -----------------------------------------------------------------------------
// apb_slave_mem
// APB4 completer terminating the transfers of the AXI4-Lite-to-APB bridge.
// Word-addressed, byte-strobed 32-bit register memory with a programmable
// number of wait states and PSLVERR on out-of-range or misaligned addresses.
//   PCLK    : APB clock, rising edge
//   PRESET  : asynchronous active-high reset (also clears the memory)
//   PSEL    : completer select
//   PENABLE : access phase indicator
//   PWRITE  : 1 = write, 0 = read
//   PADDR   : byte address
//   PWDATA  : write data
//   PSTRB   : write byte lanes
//   PRDATA  : read data, non-zero only in a completing error-free read
//   PREADY  : transfer completes in this cycle (combinational)
//   PSLVERR : error flag, only ever high together with PREADY
// Parameters: DEPTH words (>= 2), ADDR_W address bits, WAIT_STATES (0..15).
// -----------------------------------------------------------------------------
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [APB_DW-1:0] PWDATA,
    input  logic [APB_SW-1:0] PSTRB,
    output logic [APB_DW-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    localparam int unsigned     IDX_W   = $clog2(DEPTH);
    // One extra bit so DEPTH*4 is representable even when it equals 2**ADDR_W.
    localparam logic [ADDR_W:0] LIMIT   = (ADDR_W + 1)'(DEPTH * 4);
    localparam logic [3:0]      WS_LOAD = 4'(WAIT_STATES);

    apb_state_e        state_q, state_d;
    logic [3:0]        cnt_q,   cnt_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic              write_q, write_d;
    logic [APB_DW-1:0] wdata_q, wdata_d;
    logic [APB_SW-1:0] strb_q,  strb_d;
    logic              err_q,   err_d;

    logic              setup_phase;
    logic              access_phase;
    logic              addr_err;
    logic              ready;
    logic [APB_SW-1:0] mem_we;
    logic [APB_DW-1:0] mem_rdata;

    assign setup_phase  = PSEL & ~PENABLE;
    assign access_phase = PSEL &  PENABLE;

    // The full address takes part in the range check, so addresses beyond the
    // array never alias onto a valid word through the truncated index.
    assign addr_err = ({1'b0, PADDR} >= LIMIT) | (PADDR[1:0] != 2'b00);

    // ---------------------------------------------------------------- state
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            err_q   <= err_d;
        end
    end

    // ----------------------------------------------------------- next state
    // A completing transfer always returns to IDLE; a setup phase in the very
    // next cycle is captured there, so back-to-back transfers need no extra
    // cycle beyond their own setup phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        err_d   = err_q;

        unique case (state_q)
            ST_IDLE: begin
                // PSEL & PENABLE without a preceding setup phase is ignored.
                if (setup_phase) begin
                    state_d = ST_ACCESS;
                    cnt_d   = WS_LOAD;
                    idx_d   = PADDR[IDX_W+1:2];
                    write_d = PWRITE;
                    wdata_d = PWDATA;
                    strb_d  = PSTRB;
                    err_d   = addr_err;
                end
            end
            ST_ACCESS: begin
                if (access_phase) begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    // Requester abandoned the transfer before completion.
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        ready   = (state_q == ST_ACCESS) && (cnt_q == 4'd0) && access_phase;
        mem_we  = (ready && write_q && !err_q) ? strb_q : '0;
        PREADY  = ready;
        PSLVERR = ready && err_q;
        PRDATA  = (ready && !write_q && !err_q) ? mem_rdata : '0;
    end

    apb_bytemem #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk_i   (PCLK),
        .rst_i   (PRESET),
        .we_i    (mem_we),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

endmodule : apb_slave_mem
